// File: rtl/bdi_compressor_fsm.sv
// bdi_compressor_fsm: base-delta-immediate line compressor, one candidate encoding per cycle
module bdi_compressor_fsm #(
  parameter int          LINE_W  = 256,
  parameter logic [7:0]  EN_MASK = 8'hFF,
  parameter int          SZ_W    = $clog2(LINE_W/8)+1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LINE_W-1:0] in_line,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        comp_enc,
  output logic [SZ_W-1:0]   comp_size,
  output logic [LINE_W-1:0] comp_data
);
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
  localparam int NW = LINE_W/64;
  state_t state, state_n;
  logic [LINE_W-1:0] line, best_data, nxt_data;
  logic [3:0] best_enc, nxt_enc;
  logic [SZ_W-1:0] best_size, nxt_size;
  logic [2:0] idx;
  logic fit [8];
  logic [SZ_W-1:0] sz [8];
  logic [LINE_W-1:0] pk [8];
  logic rep, take, zero_hit, last;
  always_comb begin
    rep = 1'b1;
    for (int i = 1; i < NW; i++) rep = rep & (line[i*64 +: 64] == line[63:0]);
  end
  assign fit[0] = line == '0;
  assign sz[0]  = SZ_W'(1);
  assign pk[0]  = '0;
  assign fit[1] = rep;
  assign sz[1]  = SZ_W'(8);
  assign pk[1]  = LINE_W'(line[63:0]);
  // encodings 2..7: base size B bytes, delta size D bytes
  for (genvar g = 0; g < 6; g++) begin : g_bd
    localparam int B = g < 3 ? 8 : g < 5 ? 4 : 2;
    localparam int D = g == 2 ? 4 : (g == 1 || g == 4) ? 2 : 1;
    localparam int N = LINE_W/(8*B);
    logic ok;
    logic [8*B-1:0] dl;
    logic [LINE_W-1:0] p;
    always_comb begin
      ok = 1'b1;
      dl = '0;
      p = '0;
      p[8*B-1:0] = line[8*B-1:0];
      for (int i = 0; i < N; i++) begin
        dl = line[i*8*B +: 8*B] - line[8*B-1:0];
        ok = ok & (dl == {{(8*B-8*D){dl[8*D-1]}}, dl[8*D-1:0]});
        p[8*B+i*8*D +: 8*D] = dl[8*D-1:0];
      end
    end
    assign fit[g+2] = ok;
    assign sz[g+2]  = SZ_W'(B + N*D);
    assign pk[g+2]  = p;
  end
  assign take     = EN_MASK[idx] && fit[idx] && (sz[idx] < best_size);
  assign zero_hit = idx == 3'd0 && EN_MASK[0] && fit[0];
  assign last     = zero_hit || idx == 3'd7;
  assign nxt_enc  = take ? {1'b0, idx} : best_enc;
  assign nxt_size = take ? sz[idx] : best_size;
  assign nxt_data = take ? pk[idx] : best_data;
  always_comb begin
    state_n = state;
    in_ready = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        state_n = in_valid ? EVAL : IDLE;
      end
      EVAL: state_n = last ? DONE : EVAL;
      DONE: begin
        out_valid = 1'b1;
        state_n = out_ready ? IDLE : DONE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= '0;
      idx <= '0;
      best_enc <= '0;
      best_size <= '0;
      best_data <= '0;
      comp_enc <= '0;
      comp_size <= '0;
      comp_data <= '0;
    end else if (state == IDLE && in_valid) begin
      line <= in_line;
      idx <= '0;
      best_enc <= 4'd15;
      best_size <= SZ_W'(LINE_W/8);
      best_data <= in_line;
    end else if (state == EVAL) begin
      idx <= idx + 3'd1;
      best_enc <= nxt_enc;
      best_size <= nxt_size;
      best_data <= nxt_data;
      if (last) begin
        comp_enc <= nxt_enc;
        comp_size <= nxt_size;
        comp_data <= nxt_data;
      end
    end
  end
endmodule

// File: tb/tb_bdi_compressor_fsm.sv
// tb_bdi_compressor_fsm: random and directed lines against a byte-level BDI reference model
module tb_bdi_compressor_fsm;
  localparam int L = 256;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [L-1:0] in_line = '0;
  logic ir0, ir1, ov0, ov1;
  logic [3:0] enc0, enc1;
  logic [5:0] sz0, sz1;
  logic [L-1:0] d0, d1;
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  bdi_compressor_fsm #(.LINE_W(L)) dut0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(ir0), .in_line(in_line), .out_valid(ov0), .out_ready(out_ready),
    .comp_enc(enc0), .comp_size(sz0), .comp_data(d0));
  bdi_compressor_fsm #(.LINE_W(L), .EN_MASK(8'hF7)) dut1 (.clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir1), .in_line(in_line), .out_valid(ov1),
    .out_ready(out_ready), .comp_enc(enc1), .comp_size(sz1), .comp_data(d1));

  task automatic chk(input string tag, input logic [L-1:0] got, input logic [L-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned word(input logic [L-1:0] ln, input int b, input int i);
    longint unsigned w = 0;
    for (int j = 0; j < b; j++) w |= longint'(ln[(i*b+j)*8 +: 8]) << (8*j);
    return w;
  endfunction

  // smallest enabled applicable encoding, ties to the lower number
  function automatic void model(input logic [L-1:0] ln, input logic [7:0] m,
                                output logic [3:0] e, output int s, output logic [L-1:0] dt);
    int bt[8] = '{0, 0, 8, 8, 8, 4, 4, 2};
    int dd[8] = '{0, 0, 1, 2, 4, 1, 2, 1};
    e = 15; s = L/8; dt = ln;
    for (int k = 0; k < 8; k++) begin
      bit ok;
      int ks;
      logic [L-1:0] pkd;
      if (!m[k]) continue;
      pkd = '0;
      if (k == 0) begin
        ok = ln == '0; ks = 1;
      end else if (k == 1) begin
        ok = 1; ks = 8; pkd[63:0] = ln[63:0];
        for (int i = 1; i < L/64; i++) if (word(ln, 8, i) != word(ln, 8, 0)) ok = 0;
      end else begin
        int b = bt[k], d = dd[k], n = L/(8*b);
        longint unsigned msk = (b == 8) ? '1 : (64'(1) << (8*b)) - 1;
        longint unsigned ones = (64'(1) << (8*b - 8*d + 1)) - 1;
        ok = 1; ks = b + n*d;
        for (int j = 0; j < b; j++) pkd[j*8 +: 8] = ln[j*8 +: 8];
        for (int i = 0; i < n; i++) begin
          longint unsigned dl = (word(ln, b, i) - word(ln, b, 0)) & msk;
          longint unsigned top = dl >> (8*d - 1);
          if (top != 0 && top != ones) ok = 0;
          for (int j = 0; j < d; j++) pkd[(b + i*d + j)*8 +: 8] = 8'(dl >> (8*j));
        end
      end
      if (ok && ks < s) begin
        e = 4'(k); s = ks; dt = pkd;
      end
    end
  endfunction

  function automatic logic [L-1:0] rnd_line();
    logic [L-1:0] ln;
    int kind = $urandom_range(0, 5);
    int b = kind == 2 ? 8 : kind == 3 ? 4 : 2;
    int d = b == 2 ? 1 : (b == 4 ? $urandom_range(1, 2) : (1 << $urandom_range(0, 2)));
    longint unsigned base = {$urandom, $urandom};
    for (int i = 0; i < L/32; i++) ln[i*32 +: 32] = $urandom;
    if (kind == 0) ln = '0;
    else if (kind == 1) for (int i = 0; i < L/64; i++) ln[i*64 +: 64] = {$urandom, $urandom};
    if (kind == 1) for (int i = 1; i < L/64; i++) ln[i*64 +: 64] = ln[63:0];
    if (kind >= 2 && kind <= 4)
      for (int i = 0; i < L/(8*b); i++) begin
        longint t = {$urandom, $urandom};
        longint unsigned w;
        t = (t <<< (64 - 8*d)) >>> (64 - 8*d);
        w = (i == 0) ? base : base + longint'(t);
        for (int j = 0; j < b; j++) ln[(i*b+j)*8 +: 8] = 8'(w >> (8*j));
      end
    return ln;
  endfunction

  task automatic xact(input logic [L-1:0] ln, input int hold);
    logic [3:0] e; int s; logic [L-1:0] dt;
    int lat = 0;
    @(negedge clk);
    chk("in_ready_idle", L'(ir0), L'(1));
    in_line = ln; in_valid = 1;
    @(posedge clk); #1;
    in_valid = $urandom_range(0, 1); in_line = {8{$urandom}};
    while (!ov0 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", L'(lat), L'(ln == '0 ? 1 : 8));
    chk("in_ready_busy", L'(ir0), L'(0));
    model(ln, 8'hFF, e, s, dt);
    chk("enc", L'(enc0), L'(e)); chk("size", L'(sz0), L'(s)); chk("data", d0, dt);
    model(ln, 8'hF7, e, s, dt);
    chk("m_valid", L'(ov1), L'(1));
    chk("m_enc", L'(enc1), L'(e)); chk("m_size", L'(sz1), L'(s)); chk("m_data", d1, dt);
    if (hold > 0) begin
      logic [3:0] he = enc0; logic [5:0] hs = sz0; logic [L-1:0] hd = d0;
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_valid", L'(ov0), L'(1)); chk("hold_ready", L'(ir0), L'(0));
        chk("hold_enc", L'(enc0), L'(he)); chk("hold_size", L'(sz0), L'(hs));
        chk("hold_data", d0, hd);
      end
    end
    in_valid = 0;
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    chk("post_ready", L'(ir0), L'(1)); chk("post_valid", L'(ov0), L'(0));
  endtask

  initial begin
    logic [L-1:0] t2;
    t2 = {64'h66, 64'h44, 64'h22, 64'hFF};
    #1;
    chk("rst_ready", L'(ir0), L'(1)); chk("rst_valid", L'(ov0), L'(0));
    chk("rst_enc", L'(enc0), L'(0)); chk("rst_size", L'(sz0), L'(0)); chk("rst_data", d0, '0);
    #12 rst_n = 1;
    xact('0, 0);
    chk("zero_enc", L'(enc0), L'(0)); chk("zero_size", L'(sz0), L'(1));
    xact(t2, 5);
    chk("t2_enc", L'(enc0), L'(3)); chk("t2_size", L'(sz0), L'(16));
    chk("t2_data", d0, L'(128'hFF67_FF45_FF23_0000_0000_0000_0000_00FF));
    chk("t2m_enc", L'(enc1), L'(6)); chk("t2m_size", L'(sz1), L'(20));
    xact({4{64'h1122334455667788}}, 0);
    chk("rep_enc", L'(enc0), L'(1)); chk("rep_size", L'(sz0), L'(8));
    chk("rep_data", d0, L'(64'h1122334455667788));
    xact({8{32'hDEADBEEF ^ $urandom}} ^ {$urandom, 224'h0} ^ {192'h0, 64'h80}, 2);
    // reset three cycles into evaluation drops the line
    @(negedge clk); in_line = t2; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0; #1;
    chk("mid_rst_ready", L'(ir0), L'(1)); chk("mid_rst_valid", L'(ov0), L'(0));
    chk("mid_rst_enc", L'(enc0), L'(0)); chk("mid_rst_size", L'(sz0), L'(0));
    chk("mid_rst_data", d0, '0);
    @(negedge clk); rst_n = 1;
    xact(t2, 0);
    chk("after_rst_enc", L'(enc0), L'(3));
    for (int n = 0; n < 60; n++) xact(rnd_line(), $urandom_range(0, 2));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
